// File: rtl/bridge_mem_adapter.sv
// Purpose: turns bridge pmp_wr/pmp_rd strobes into a req/ack memory cycle (read-ahead reads, 1-deep write post).
// Latency: strobe to mem_req is 1 cycle; read data lands in pmp_rd_data on the mem_ack edge; re-issue 2 cycles after ack.
// Backpressure: none toward the bridge; writes while busy post 1 deep, further strobes drop and raise err_overflow.
module bridge_mem_adapter #(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK  = 32'hF000_0000,
  parameter int          READ_AHEAD = 4,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] DEFAULT_RD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pmp_addr,
  input  logic        pmp_addr_valid,
  input  logic        pmp_rd,
  input  logic        pmp_wr,
  input  logic [31:0] pmp_wr_data,
  output logic [31:0] pmp_rd_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        err_overflow,
  output logic        err_timeout,
  input  logic        err_clear
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0]  TMO_LIMIT = 8'(TIMEOUT);
  localparam logic [31:0] RA_OFFSET = 32'(READ_AHEAD);

  state_t      state_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] rd_data_q;
  logic [7:0]  tmo_cnt_q;
  logic        post_full_q;
  logic [31:0] post_addr_q;
  logic [31:0] post_data_q;
  logic        err_ovf_q;
  logic        err_tmo_q;

  logic        wr_s;
  logic        rd_s;
  logic        hit;
  logic        is_idle;
  logic        issue_post;
  logic        issue_wr;
  logic        issue_rd;
  logic        rd_miss;
  logic        post_store;
  logic        wr_drop;
  logic        rd_drop;
  logic        ack_evt;
  logic        tmo_evt;
  logic [7:0]  tmo_cnt_d;
  logic [31:0] rd_target_d;

  // Strobe qualification, window decode and the issue/drop decisions for this cycle.
  always_comb begin
    wr_s        = pmp_wr & pmp_addr_valid;
    rd_s        = pmp_rd & pmp_addr_valid;
    hit         = ((pmp_addr & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
    is_idle     = (state_q == IDLE);
    rd_target_d = pmp_addr + RA_OFFSET;
    tmo_cnt_d   = tmo_cnt_q + 8'd1;

    // A pending post always goes first out of IDLE.
    issue_post  = is_idle & post_full_q;
    issue_wr    = is_idle & ~post_full_q & wr_s & hit;
    // A read that collides with a write strobe is never served.
    issue_rd    = is_idle & ~post_full_q & ~wr_s & rd_s & hit;
    rd_miss     = is_idle & ~post_full_q & ~wr_s & rd_s & ~hit;

    // The post slot frees up in the same cycle it is issued, so it can refill.
    post_store  = wr_s & hit & (issue_post | (~is_idle & ~post_full_q));
    wr_drop     = wr_s & hit & ~is_idle & post_full_q;
    rd_drop     = rd_s & (wr_s | ~is_idle | post_full_q);

    ack_evt     = (state_q == REQ) & mem_ack;
    tmo_evt     = (state_q == REQ) & ~mem_ack & (tmo_cnt_d == TMO_LIMIT);
  end

  // Transaction FSM: owns every memory-side output and the read data register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      rd_data_q   <= DEFAULT_RD;
      tmo_cnt_q   <= 8'h0;
    end else begin
      case (state_q)
        IDLE: begin
          tmo_cnt_q <= 8'h0;
          if (issue_post) begin
            state_q     <= REQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= post_addr_q;
            mem_wdata_q <= post_data_q;
          end else if (issue_wr) begin
            state_q     <= REQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= pmp_addr;
            mem_wdata_q <= pmp_wr_data;
          end else if (issue_rd) begin
            state_q     <= REQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= rd_target_d;
          end else if (rd_miss) begin
            rd_data_q   <= DEFAULT_RD;
          end
        end
        REQ: begin
          if (ack_evt) begin
            if (!mem_we_q) begin
              rd_data_q <= mem_rdata;
            end
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            tmo_cnt_q <= 8'h0;
          end else if (tmo_evt) begin
            if (!mem_we_q) begin
              rd_data_q <= DEFAULT_RD;
            end
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            tmo_cnt_q <= 8'h0;
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
          end
        end
        DONE: begin
          // Any mem_ack arriving here is late and deliberately ignored.
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // One-entry write post buffer; loads on a posted strobe, empties when issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      post_full_q <= 1'b0;
      post_addr_q <= 32'h0;
      post_data_q <= 32'h0;
    end else if (post_store) begin
      post_full_q <= 1'b1;
      post_addr_q <= pmp_addr;
      post_data_q <= pmp_wr_data;
    end else if (issue_post) begin
      post_full_q <= 1'b0;
    end
  end

  // Sticky error flags; a new event in the clearing cycle wins over err_clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_ovf_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      err_ovf_q <= (err_ovf_q & ~err_clear) | wr_drop | rd_drop;
      err_tmo_q <= (err_tmo_q & ~err_clear) | tmo_evt;
    end
  end

  assign pmp_rd_data  = rd_data_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = (state_q != IDLE) | post_full_q;
  assign err_overflow = err_ovf_q;
  assign err_timeout  = err_tmo_q;

endmodule

// File: doc/bridge_mem_adapter.md
Name: bridge_mem_adapter

Overview:
- Sits directly downstream of the SPI/PMP bridge peripheral.
- Converts its single-cycle pmp_wr / pmp_rd strobes into a req/ack memory transaction toward SDRAM/BRAM arbiters.
- Returns read data on the read-ahead convention: a pmp_rd strobe fetches the next sequential word, which must be stable on pmp_rd_data before the next bridge read samples it.
- Also handles address-window decode, one-deep write posting, and ack timeout.

Parameters:
ADDR_BASE, 32'h0000_0000, base byte address of the decoded window
ADDR_MASK, 32'hF000_0000, bits of pmp_addr compared against ADDR_BASE
READ_AHEAD, 4, byte offset added to the captured address on a pmp_rd prefetch
TIMEOUT, 255, cycles to wait for mem_ack before aborting (8-bit counter)
DEFAULT_RD, 32'hFFFF_FFFF, data returned for out-of-window or timed-out reads

Ports:
clk  in  1  system clock (74.25 MHz domain)
reset_n  in  1  asynchronous active-low reset
pmp_addr  in  32  word-aligned byte address from bridge
pmp_addr_valid  in  1  address valid level
pmp_rd  in  1  1-cycle read-ahead kick
pmp_wr  in  1  1-cycle write strobe
pmp_wr_data  in  32  write data, valid during pmp_wr
pmp_rd_data  out  32  registered read data presented to bridge
mem_req  out  1  request level, held until mem_ack
mem_we  out  1  1=write, 0=read, stable while mem_req
mem_addr  out  32  byte address, stable while mem_req
mem_wdata  out  32  write data, stable while mem_req
mem_ack  in  1  1-cycle completion; mem_rdata valid the same cycle
mem_rdata  in  32  read data
busy  out  1  high whenever state != IDLE or a post is pending
err_overflow  out  1  sticky: write strobe dropped
err_timeout  out  1  sticky: ack timeout occurred
err_clear  in  1  clears both sticky flags

Behaviour:
- Reset (async, reset_n=0): state=IDLE; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; pmp_rd_data=DEFAULT_RD; busy=0; err_*=0; post buffer empty; timeout counter=0.
- Window hit: (addr & ADDR_MASK) == (ADDR_BASE & ADDR_MASK).
- Strobes while pmp_addr_valid=0 are ignored.
- States:
  - IDLE: a pending post has priority, then pmp_wr, then pmp_rd.
  - REQ: mem_req=1; timeout counter increments every cycle.
  - DONE: one cycle, clears mem_req.
- Write, hit: capture pmp_addr and pmp_wr_data the strobe cycle; mem_req=1, mem_we=1 on the next cycle (1-cycle latency).
- Write, miss: discarded, no mem cycle.
- Read, hit: target = pmp_addr + READ_AHEAD (32-bit wrap, no carry beyond bit 31); mem_req=1, mem_we=0 next cycle.
- Read, miss: pmp_rd_data <= DEFAULT_RD on the cycle after the strobe.
- On mem_ack in REQ: read loads pmp_rd_data <= mem_rdata that edge; then DONE → mem_req=0 → IDLE. Earliest re-issue is 2 cycles after ack.
- pmp_rd_data changes only on read completion, timeout, or miss; it holds otherwise, including across writes.
- Posting: pmp_wr while not IDLE stores into a 1-entry post buffer.
  - If the buffer is already full, the strobe is dropped and err_overflow is set.
  - pmp_rd while not IDLE is dropped, and err_overflow is set.
- Timeout: counter reaching TIMEOUT in REQ forces DONE with mem_req=0 and sets err_timeout. A read also loads pmp_rd_data <= DEFAULT_RD. A late mem_ack outside REQ is ignored.
- Simultaneous pmp_wr and pmp_rd in one cycle: write served, read dropped, err_overflow set.
- err_clear and a new error event in the same cycle: the flag ends set.
- busy = (state != IDLE) | post_full.

Test Plan:
- Write hit: pmp_addr=32'h0000_0100, pmp_wr_data=32'hCAFEBABE, pmp_wr pulse → next cycle mem_req=1, mem_we=1, mem_addr=32'h100, mem_wdata=32'hCAFEBABE; ack at +3 → mem_req=0 the cycle after, busy=0 one cycle later.
- Read-ahead: pmp_addr=32'h200, pmp_rd → mem_addr=32'h204, mem_we=0; ack with mem_rdata=32'h12345678 → pmp_rd_data=32'h12345678 on the following edge, held through a subsequent write.
- Window miss: pmp_addr=32'h1000_0000, pmp_rd → no mem_req; pmp_rd_data=32'hFFFFFFFF next cycle. pmp_wr to the same address → no mem_req, no error.
- Posting/overflow: three pmp_wr pulses 1 cycle apart, ack held off → first issued, second posted and issued after the first ack, third dropped with err_overflow=1; err_clear → 0.
- Timeout: pmp_rd hit, mem_ack never asserted → mem_req drops after 255 cycles, err_timeout=1, pmp_rd_data=32'hFFFFFFFF; late ack ignored.
- Async reset mid-REQ: reset_n low for 1 ns mid-cycle → mem_req=0, pmp_rd_data=32'hFFFFFFFF immediately; post buffer cleared, no transaction after release.
